// File: rtl/ilm_ecc_loader.sv
// ilm_ecc_loader
// ----------------------------------------------------------------------------
// Boot-time preload engine for the N100 instruction local memory (ILM).
// A little-endian byte stream (boot UART / debug bridge) is packed into
// 32-bit words. Each word gets a 7-bit SECDED code and a zero flag bit, and
// is written as a 40-bit word into the ILM SRAM write port. Optionally the
// rest of the ILM is zero-filled. The core is held in reset until the load
// completes.
//
// Parameters:
//   ILM_RAM_DP  ILM depth in 32-bit words
//   ILM_AW      ILM word address width, clog2(ILM_RAM_DP)
//   HAS_ECC     1 = generate code bits [38:32], 0 = bits [39:32] are zero
//
// Ports:
//   clk        core clock
//   rst        synchronous active-high reset
//   start      one-cycle load request, only honoured while idle
//   load_len   number of words to load (clamped to ILM_RAM_DP), taken with start
//   fill_en    zero-fill words load_len..ILM_RAM_DP-1, taken with start
//   s_valid    byte stream valid
//   s_data     byte stream data, first byte lands in word bits [7:0]
//   s_ready    byte accepted when s_valid & s_ready
//   ram_cs     ILM chip select
//   ram_we     ILM write enable
//   ram_addr   ILM word address
//   ram_din    ILM write data {flag, ecc[6:0], data[31:0]}
//   core_hold  high keeps the core in reset
//   busy       load in progress
//   done       one-cycle pulse when the load finishes
// ----------------------------------------------------------------------------
module ilm_ecc_loader #(
    parameter int ILM_RAM_DP = 8192,
    parameter int ILM_AW     = 13,
    parameter int HAS_ECC    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ILM_AW:0]   load_len,
    input  logic              fill_en,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ILM_AW-1:0] ram_addr,
    output logic [39:0]       ram_din,
    output logic              core_hold,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        FILL,
        DONE
    } state_t;

    // Depth expressed in the one-bit-wider counter width so that "one past
    // the last word" is representable and the address never has to wrap.
    localparam logic [ILM_AW:0] DEPTH = (ILM_AW + 1)'(ILM_RAM_DP);

    // Parity masks for code bits e0..e5; e6 is the overall parity.
    localparam logic [31:0] MASK0 = 32'h56AA_AD5B;
    localparam logic [31:0] MASK1 = 32'h9B33_366D;
    localparam logic [31:0] MASK2 = 32'hE3C3_C78E;
    localparam logic [31:0] MASK3 = 32'h03FC_07F0;
    localparam logic [31:0] MASK4 = 32'h03FF_F800;
    localparam logic [31:0] MASK5 = 32'hFC00_0000;

    state_t          state;
    logic [ILM_AW:0] len;
    logic [ILM_AW:0] addr;
    logic            fill_q;
    logic [1:0]      byte_cnt;
    logic [31:0]     word;

    logic [ILM_AW:0] addr_next;
    logic [ILM_AW:0] len_clamped;
    logic [31:0]     next_word;
    logic [6:0]      ecc;
    logic [7:0]      code;
    logic            byte_take;

    // Merge the incoming byte into its lane so the full word (and its code)
    // is available in the same cycle the fourth byte is accepted. This lets
    // the WRITE cycle present registered data without an extra stage.
    always_comb begin
        next_word = word;
        next_word[{byte_cnt, 3'b000} +: 8] = s_data;
    end

    // SECDED code over the assembled word. The flag bit and the code are
    // forced to zero when ECC is not built in.
    always_comb begin
        ecc[0] = ^(next_word & MASK0);
        ecc[1] = ^(next_word & MASK1);
        ecc[2] = ^(next_word & MASK2);
        ecc[3] = ^(next_word & MASK3);
        ecc[4] = ^(next_word & MASK4);
        ecc[5] = ^(next_word & MASK5);
        ecc[6] = (^next_word) ^ (^ecc[5:0]);
        code   = (HAS_ECC != 0) ? {1'b0, ecc} : 8'h00;
    end

    // Address increment, load length clamp to the ILM depth, and the
    // byte handshake as seen by the state machine.
    always_comb begin
        addr_next   = addr + (ILM_AW + 1)'(1);
        len_clamped = (load_len > DEPTH) ? DEPTH : load_len;
        byte_take   = s_valid && s_ready && (state == LOAD);
    end

    // Main sequencer. Every output is a register set on the transition into
    // the state that owns it, so the RAM sees clean, glitch-free strobes.
    // core_hold powers up high and is only released when a load finishes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len       <= '0;
            addr      <= '0;
            fill_q    <= 1'b0;
            byte_cnt  <= 2'd0;
            word      <= 32'h0;
            s_ready   <= 1'b0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= 40'h0;
            core_hold <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len       <= len_clamped;
                        fill_q    <= fill_en;
                        addr      <= '0;
                        byte_cnt  <= 2'd0;
                        word      <= 32'h0;
                        busy      <= 1'b1;
                        core_hold <= 1'b1;
                        if (len_clamped != '0) begin
                            state   <= LOAD;
                            s_ready <= 1'b1;
                        end else if (fill_en) begin
                            state    <= FILL;
                            ram_cs   <= 1'b1;
                            ram_we   <= 1'b1;
                            ram_addr <= '0;
                            ram_din  <= 40'h0;
                        end else begin
                            state     <= DONE;
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                        end
                    end
                end

                LOAD: begin
                    if (byte_take) begin
                        word     <= next_word;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state    <= WRITE;
                            s_ready  <= 1'b0;
                            ram_cs   <= 1'b1;
                            ram_we   <= 1'b1;
                            ram_addr <= addr[ILM_AW-1:0];
                            ram_din  <= {code, next_word};
                        end
                    end
                end

                WRITE: begin
                    addr <= addr_next;
                    if (addr_next < len) begin
                        state   <= LOAD;
                        s_ready <= 1'b1;
                        ram_cs  <= 1'b0;
                        ram_we  <= 1'b0;
                    end else if (fill_q && (len < DEPTH)) begin
                        state    <= FILL;
                        ram_addr <= addr_next[ILM_AW-1:0];
                        ram_din  <= 40'h0;
                    end else begin
                        state     <= DONE;
                        ram_cs    <= 1'b0;
                        ram_we    <= 1'b0;
                        done      <= 1'b1;
                        core_hold <= 1'b0;
                    end
                end

                // A zero word has a zero code, so the fill data is constant.
                FILL: begin
                    if (addr_next == DEPTH) begin
                        state     <= DONE;
                        ram_cs    <= 1'b0;
                        ram_we    <= 1'b0;
                        done      <= 1'b1;
                        core_hold <= 1'b0;
                    end else begin
                        addr     <= addr_next;
                        ram_addr <= addr_next[ILM_AW-1:0];
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ilm_ecc_loader.sv
// tb_ilm_ecc_loader
// ----------------------------------------------------------------------------
// Self-checking bench for ilm_ecc_loader with a 16-word ILM. A second copy
// built without ECC runs on the same stimulus so the code-less data format
// is checked on every write. Expected RAM writes are queued when a word is
// streamed in and popped by a write monitor.
// ----------------------------------------------------------------------------
module tb_ilm_ecc_loader;

    localparam int DP = 16;
    localparam int AW = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [39:0]   din;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW:0]   load_len;
    logic          fill_en;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_ready;
    logic          ram_cs;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [39:0]   ram_din;
    logic          core_hold;
    logic          busy;
    logic          done;

    logic          ne_s_ready;
    logic          ne_ram_cs;
    logic          ne_ram_we;
    logic [AW-1:0] ne_ram_addr;
    logic [39:0]   ne_ram_din;
    logic          ne_core_hold;
    logic          ne_busy;
    logic          ne_done;

    int   checks;
    int   fails;
    int   cyc;
    int   write_count;
    int   last_write_cyc;
    int   extra_acc;
    bit   watch_extra;
    exp_t sb[$];
    int   wr_cyc[$];

    ilm_ecc_loader #(.ILM_RAM_DP(DP), .ILM_AW(AW), .HAS_ECC(1)) dut (
        .clk(clk), .rst(rst), .start(start), .load_len(load_len),
        .fill_en(fill_en), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .ram_cs(ram_cs), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_din(ram_din), .core_hold(core_hold),
        .busy(busy), .done(done)
    );

    ilm_ecc_loader #(.ILM_RAM_DP(DP), .ILM_AW(AW), .HAS_ECC(0)) dut_noecc (
        .clk(clk), .rst(rst), .start(start), .load_len(load_len),
        .fill_en(fill_en), .s_valid(s_valid), .s_data(s_data),
        .s_ready(ne_s_ready), .ram_cs(ne_ram_cs), .ram_we(ne_ram_we),
        .ram_addr(ne_ram_addr), .ram_din(ne_ram_din),
        .core_hold(ne_core_hold), .busy(ne_busy), .done(ne_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference SECDED code built straight from the bit lists.
    function automatic logic [6:0] eccModel(input logic [31:0] d);
        int r0[18] = '{0,1,3,4,6,8,10,11,13,15,17,19,21,23,25,26,28,30};
        int r1[18] = '{0,2,3,5,6,9,10,12,13,16,17,20,21,24,25,27,28,31};
        int r2[18] = '{1,2,3,7,8,9,10,14,15,16,17,22,23,24,25,29,30,31};
        logic [6:0] e;
        e = 7'h0;
        for (int i = 0; i < 18; i++) begin
            e[0] = e[0] ^ d[r0[i]];
            e[1] = e[1] ^ d[r1[i]];
            e[2] = e[2] ^ d[r2[i]];
        end
        for (int i = 4; i <= 10; i++) e[3] = e[3] ^ d[i];
        for (int i = 18; i <= 25; i++) e[3] = e[3] ^ d[i];
        for (int i = 11; i <= 25; i++) e[4] = e[4] ^ d[i];
        for (int i = 26; i <= 31; i++) e[5] = e[5] ^ d[i];
        e[6] = 1'b0;
        for (int i = 0; i < 32; i++) e[6] = e[6] ^ d[i];
        for (int i = 0; i < 6; i++) e[6] = e[6] ^ e[i];
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    // Write monitor: every RAM write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (ram_cs && ram_we) begin
            checkOutput("sb_pending", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("ram_addr", 64'(ram_addr), 64'(e.addr));
                checkOutput("ram_din", 64'(ram_din), 64'(e.din));
                checkOutput("noecc_din", 64'(ne_ram_din),
                            64'({8'h00, e.din[31:0]}));
                checkOutput("s_ready_in_write", 64'(s_ready), 64'd0);
            end
            write_count++;
            last_write_cyc = cyc;
            wr_cyc.push_back(cyc);
        end
        if (watch_extra && s_valid && s_ready) extra_acc++;
    end

    task automatic doReset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic startLoad(input int len, input bit fill);
        start    = 1'b1;
        load_len = (AW + 1)'(len);
        fill_en  = fill;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        bit ok;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = b;
        for (int i = 0; i < 50; i++) begin
            if (s_ready) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        if (!ok) checkOutput("byte_accept_timeout", 64'(ok), 64'd1);
    endtask

    // Queue the expected write and stream the word; optionally idle the
    // stream for 3 cycles after byte index stall_after.
    task automatic applyStimulus(input logic [31:0] w, input int a,
                                 input logic [39:0] exp_din,
                                 input int stall_after);
        exp_t e;
        e.addr = AW'(a);
        e.din  = exp_din;
        sb.push_back(e);
        for (int i = 0; i < 4; i++) begin
            sendByte(w[i*8 +: 8]);
            if (i == stall_after) begin
                s_valid = 1'b0;
                repeat (3) @(negedge clk);
            end
        end
    endtask

    task automatic waitDone();
        for (int i = 0; i < 200; i++) begin
            if (done) break;
            @(negedge clk);
        end
        checkOutput("done_seen", 64'(done), 64'd1);
        if (done) begin
            checkOutput("core_hold_at_done", 64'(core_hold), 64'd0);
            checkOutput("busy_at_done", 64'(busy), 64'd1);
            checkOutput("sb_drained", 64'(sb.size()), 64'd0);
            checkOutput("write_to_done", 64'(cyc - last_write_cyc), 64'd1);
            @(negedge clk);
            checkOutput("done_pulse", 64'(done), 64'd0);
            checkOutput("busy_after_done", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        logic [31:0] w;
        checks      = 0;
        fails       = 0;
        cyc         = 0;
        write_count = 0;
        extra_acc   = 0;
        watch_extra = 1'b0;
        rst         = 1'b1;
        start       = 1'b0;
        load_len    = '0;
        fill_en     = 1'b0;
        s_valid     = 1'b0;
        s_data      = 8'h00;

        doReset();
        checkOutput("rst_s_ready", 64'(s_ready), 64'd0);
        checkOutput("rst_ram_cs", 64'(ram_cs), 64'd0);
        checkOutput("rst_ram_we", 64'(ram_we), 64'd0);
        checkOutput("rst_ram_addr", 64'(ram_addr), 64'd0);
        checkOutput("rst_ram_din", 64'(ram_din), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_core_hold", 64'(core_hold), 64'd1);

        $display("[TB] single word 0x00000013");
        startLoad(1, 1'b0);
        checkOutput("start_to_s_ready", 64'(s_ready), 64'd1);
        checkOutput("busy_after_start", 64'(busy), 64'd1);
        applyStimulus(32'h0000_0013, 0, 40'h4F_0000_0013, -1);
        s_valid = 1'b0;
        checkOutput("core_hold_loading", 64'(core_hold), 64'd1);
        waitDone();

        $display("[TB] single word 0xFFFFFFFF");
        startLoad(1, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 0, 40'h18_FFFF_FFFF, -1);
        s_valid = 1'b0;
        checkOutput("core_hold_reload", 64'(core_hold), 64'd1);
        waitDone();

        $display("[TB] two words with mid-word stall");
        base = write_count;
        startLoad(2, 1'b0);
        w = 32'hA1B2_C3D4;
        applyStimulus(w, 0, {1'b0, eccModel(w), w}, 1);
        w = $urandom;
        applyStimulus(w, 1, {1'b0, eccModel(w), w}, -1);
        s_valid = 1'b0;
        waitDone();
        checkOutput("stall_write_count", 64'(write_count - base), 64'd2);

        $display("[TB] zero fill of whole ILM");
        base = write_count;
        for (int i = 0; i < DP; i++) begin
            exp_t e;
            e.addr = AW'(i);
            e.din  = 40'h0;
            sb.push_back(e);
        end
        startLoad(0, 1'b1);
        waitDone();
        checkOutput("fill_write_count", 64'(write_count - base), 64'(DP));

        $display("[TB] oversized load_len is clamped");
        base = write_count;
        startLoad(DP + 5, 1'b1);
        for (int i = 0; i < DP; i++) begin
            w = $urandom;
            applyStimulus(w, i, {1'b0, eccModel(w), w}, -1);
        end
        s_data      = 8'hEE;
        watch_extra = 1'b1;
        waitDone();
        repeat (4) @(negedge clk);
        watch_extra = 1'b0;
        s_valid     = 1'b0;
        checkOutput("extra_bytes_accepted", 64'(extra_acc), 64'd0);
        checkOutput("clamp_write_count", 64'(write_count - base), 64'(DP));
        checkOutput("throughput", 64'(wr_cyc[base + DP - 1] - wr_cyc[base]),
                    64'(5 * (DP - 1)));

        $display("[TB] reset in the middle of word 3");
        base = write_count;
        startLoad(4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            applyStimulus(w, i, {1'b0, eccModel(w), w}, -1);
        end
        sendByte(8'h5A);
        sendByte(8'hA5);
        s_valid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        checkOutput("midrst_s_ready", 64'(s_ready), 64'd0);
        checkOutput("midrst_ram_we", 64'(ram_we), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_core_hold", 64'(core_hold), 64'd1);
        checkOutput("midrst_ram_din", 64'(ram_din), 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("midrst_write_count", 64'(write_count - base), 64'd3);
        checkOutput("midrst_hold_after", 64'(core_hold), 64'd1);
        startLoad(1, 1'b0);
        applyStimulus(32'hCAFE_F00D, 0,
                      {1'b0, eccModel(32'hCAFE_F00D), 32'hCAFE_F00D}, -1);
        s_valid = 1'b0;
        waitDone();

        $display("[TB] End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
